// File: rtl/cdb_arbiter_pkg.sv
// Shared CPU types for the Common Data Bus: tag/data broadcast record,
// the idle tag, and the functional-unit numbering used by the CDB arbiter.
package cpu_types;

    localparam int TAG_W = 5;

    typedef logic [TAG_W-1:0] RS_tag_type;

    localparam RS_tag_type INVALID = '0;

    typedef struct packed {
        RS_tag_type  tag;
        logic [31:0] data;
    } cdb_t;

    localparam int CDB_N_FU = 4;

    localparam int FU_ALU   = 0;
    localparam int FU_LOAD  = 1;
    localparam int FU_STORE = 2;
    localparam int FU_BR    = 3;

    localparam cdb_t CDB_IDLE = '{tag: INVALID, data: 32'd0};

    function automatic logic is_idle(input cdb_t c);
        return c.tag == INVALID;
    endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Handshake bundle between the functional units (master) and the CDB arbiter (slave).
interface cdb_arbiter_if import cpu_types::*; #(
    parameter int N_FU = CDB_N_FU
) ();

    logic [N_FU-1:0] req_valid;
    cdb_t            req [N_FU];
    logic            flush;
    logic [N_FU-1:0] grant;
    cdb_t            cdb_out;
    logic            cdb_stall;

    modport master (
        output req_valid,
        output req,
        output flush,
        input  grant,
        input  cdb_out,
        input  cdb_stall
    );

    modport slave (
        input  req_valid,
        input  req,
        input  flush,
        output grant,
        output cdb_out,
        output cdb_stall
    );

endinterface

// File: rtl/cdb_arbiter_rr.sv
// Combinational round-robin picker: the first set request at or after ptr,
// wrapping modulo N (not 2**PW). Reusable for issue-queue selection.
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] gnt_idx
);

    logic [PW:0] cand;
    logic        found;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        cand    = '0;
        for (int k = 0; k < N; k++) begin
            // ptr < N, so one conditional subtract is enough to wrap
            cand = {1'b0, ptr} + (PW+1)'(k);
            if (cand >= (PW+1)'(N)) begin
                cand = cand - (PW+1)'(N);
            end
            if (!found && req[cand[PW-1:0]]) begin
                found                = 1'b1;
                gnt[cand[PW-1:0]]    = 1'b1;
                gnt_idx              = cand[PW-1:0];
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: one round-robin winner per cycle, registered onto
// cdb_out for a single cycle; losers hold and see cdb_stall.
module cdb_arbiter import cpu_types::*; #(
    parameter  int N_FU  = CDB_N_FU,
    localparam int PTR_W = $clog2(N_FU)
) (
    input  logic         clk,
    input  logic         rst_n,
    cdb_arbiter_if.slave bus
);

    logic [PTR_W-1:0] ptr_reg;
    logic [PTR_W-1:0] ptr_next;
    logic [PTR_W-1:0] gnt_idx;
    logic [N_FU-1:0]  req_eff;
    logic [N_FU-1:0]  gnt;
    logic [N_FU-1:0]  req_bad;
    logic             transfer;

    // A squash hides every request, so nothing is granted and nobody stalls.
    assign req_eff = bus.flush ? '0 : bus.req_valid;

    rr_arbiter #(.N(N_FU)) u_rr (
        .req     (req_eff),
        .ptr     (ptr_reg),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign bus.grant = gnt;
    assign transfer  = |gnt;

    always_comb begin
        ptr_next = ptr_reg;
        if (transfer) begin
            ptr_next = (gnt_idx == PTR_W'(N_FU-1)) ? '0 : gnt_idx + PTR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg       <= '0;
            bus.cdb_out   <= CDB_IDLE;
            bus.cdb_stall <= 1'b0;
        end else begin
            ptr_reg <= ptr_next;
            // A malformed (INVALID-tag) request is drained but leaves the bus idle.
            if (transfer && !is_idle(bus.req[gnt_idx])) begin
                bus.cdb_out <= bus.req[gnt_idx];
            end else begin
                bus.cdb_out <= CDB_IDLE;
            end
            bus.cdb_stall <= ($countones(req_eff) > int'(transfer));
        end
    end

    for (genvar gi = 0; gi < N_FU; gi++) begin : g_bad
        assign req_bad[gi] = bus.req_valid[gi] && (bus.req[gi].tag == INVALID);
    end

    a_no_invalid_tag: assert property (@(posedge clk) disable iff (!rst_n) req_bad == '0)
        else $error("cdb_arbiter: valid request carries INVALID tag (0x%0h)", req_bad);

endmodule
